mult: RTL and testbench

- Multi-cycle signed multiplier, the companion to the iterative divider in the ALU's MULT/DIV path.
- Uses the same handshake as the divider:
  - one-cycle `enable` pulse latches the operands;
  - `ready` pulses when the result is valid;
  - `exception` flags a result that does not fit.
- Radix-2 Booth algorithm, one step per cycle.
- The divider's bench (for example 10/2=5) can cross-check against it (5*2=10).

---
 rtl/mult_div_pkg.sv | 18 +
 rtl/mult_booth_step.sv | 30 +++
 rtl/mult.sv | 116 +++++++++++
 tb/tb_mult.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_pkg.sv
// Shared definitions for the ALU MULT/DIV path.
// Holds the default width, the FSM state encoding and counter sizing.
package mult_div_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to count 0..w-1; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/mult_booth_step.sv
// One radix-2 Booth iteration on the packed product register.
// Adds or subtracts M in the upper field, then shifts right arithmetically.
module mult_booth_step
    import mult_div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [2*WIDTH+1:0] p,
    input  logic [WIDTH-1:0]   m,
    output logic [2*WIDTH+1:0] p_next
);

    logic [WIDTH:0] m_ext;
    logic [WIDTH:0] upper;
    logic [WIDTH:0] sum;

    // Booth recode on the low pair, then shift the whole register by one.
    always_comb begin
        m_ext = {m[WIDTH-1], m};
        upper = p[2*WIDTH+1:WIDTH+1];
        sum   = upper;
        unique case (p[1:0])
            2'b01:   sum = upper + m_ext;
            2'b10:   sum = upper - m_ext;
            default: sum = upper;
        endcase
        p_next = {sum[WIDTH], sum, p[WIDTH:1]};
    end

endmodule

// File: rtl/mult.sv
// Iterative signed multiplier, one Booth step per clock.
// Same enable/ready/exception handshake as the iterative divider.
module mult
    import mult_div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic [WIDTH-1:0] result,
    output logic             ready,
    output logic             exception
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t state;
    state_t next_state;

    logic [2*WIDTH+1:0] p;
    logic [2*WIDTH+1:0] p_next;
    logic [WIDTH-1:0]   m_reg;
    logic [CW-1:0]      counter;
    logic [WIDTH:0]     high;

    logic load;
    logic step_en;
    logic finish;

    mult_booth_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .p      (p),
        .m      (m_reg),
        .p_next (p_next)
    );

    // Sign bit of the low word plus everything above it; all equal means it fits.
    assign high  = p_next[2*WIDTH:WIDTH];
    assign ready = (state == DONE);

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and datapath controls; starts are only taken outside BUSY.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        step_en    = 1'b0;
        finish     = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable) begin
                    load       = 1'b1;
                    next_state = BUSY;
                end
            end
            BUSY: begin
                step_en = 1'b1;
                if (counter == LAST) begin
                    finish     = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                if (enable) begin
                    load       = 1'b1;
                    next_state = BUSY;
                end else begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Operand latch, product iteration and step counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            p       <= '0;
            m_reg   <= '0;
            counter <= '0;
        end else if (load) begin
            m_reg   <= multiplicand;
            p       <= {{(WIDTH + 1){1'b0}}, multiplier, 1'b0};
            counter <= '0;
        end else if (step_en) begin
            p       <= p_next;
            counter <= counter + CW'(1);
        end
    end

    // Outputs change only on the final step and hold until the next one.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            result    <= '0;
            exception <= 1'b0;
        end else if (finish) begin
            result    <= p_next[WIDTH:1];
            exception <= ~((&high) | ~(|high));
        end
    end

endmodule

// File: tb/tb_mult.sv
// Bench for mult: directed vectors with literal expectations plus a
// cycle-level reference model compared against the outputs every cycle.
module tb_mult;

    localparam int W = 32;

    logic         clock;
    logic         reset;
    logic         enable;
    logic [W-1:0] multiplicand;
    logic [W-1:0] multiplier;
    logic [W-1:0] result;
    logic         ready;
    logic         exception;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    mult #(.WIDTH(W)) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .result       (result),
        .ready        (ready),
        .exception    (exception)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: plain 64-bit signed product, timed by cycle count.
    int           cyc = 0;
    bit           m_busy = 0;
    int           end_cyc = 0;
    bit           m_rdy = 0;
    logic [W-1:0] m_res = '0;
    bit           m_exc = 0;
    logic [W-1:0] pend_res;
    bit           pend_exc;

    always @(posedge clock or posedge reset) begin
        longint full;
        bit     can;
        if (reset) begin
            m_busy = 0;
            m_rdy  = 0;
            m_res  = '0;
            m_exc  = 0;
        end else begin
            cyc++;
            can   = !m_busy;
            m_rdy = 0;
            if (m_busy && cyc == end_cyc) begin
                m_busy = 0;
                m_rdy  = 1;
                m_res  = pend_res;
                m_exc  = pend_exc;
            end
            if (can && enable) begin
                full     = longint'($signed(multiplicand)) *
                           longint'($signed(multiplier));
                pend_res = full[W-1:0];
                pend_exc = (full != longint'($signed(full[W-1:0])));
                m_busy   = 1;
                end_cyc  = cyc + W;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every cycle, outputs must agree with the model.
    always @(negedge clock) begin
        if (chk_en) begin
            check("model_ready", 64'(ready), 64'(m_rdy));
            check("model_result", 64'(result), 64'(m_res));
            check("model_exception", 64'(exception), 64'(m_exc));
        end
    end

    task automatic wait_ready(input string name, input int t0,
                              output bit seen);
        seen = 0;
        for (int k = 0; k < W + 8; k++) begin
            if (ready) begin
                seen = 1;
                break;
            end
            @(negedge clock);
        end
        check({name, "_seen"}, 64'(seen), 64'd1);
        if (seen) check({name, "_latency"}, 64'(cyc - t0), 64'(W));
    endtask

    task automatic run_op(input string name, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] er,
                          input bit ee);
        int t0;
        bit seen;
        multiplicand = a;
        multiplier   = b;
        enable       = 1'b1;
        @(posedge clock);
        @(negedge clock);
        t0           = cyc;
        enable       = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
        wait_ready(name, t0, seen);
        if (seen) begin
            check({name, "_result"}, 64'(result), 64'(er));
            check({name, "_exception"}, 64'(exception), 64'(ee));
        end
        @(negedge clock);
    endtask

    typedef struct {
        string        name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        bit           e;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int  t0;
        int  cnt;
        bit  seen;

        vecs.push_back('{"mul_10x2",   32'd10,         32'd2,          32'h00000014, 1'b0});
        vecs.push_back('{"mul_m7x6",   32'hFFFFFFF9,   32'h00000006,   32'hFFFFFFD6, 1'b0});
        vecs.push_back('{"ovf_2p32",   32'h00010000,   32'h00010000,   32'h00000000, 1'b1});
        vecs.push_back('{"ovf_minxm1", 32'h80000000,   32'hFFFFFFFF,   32'h80000000, 1'b1});
        vecs.push_back('{"max_x1",     32'h7FFFFFFF,   32'h00000001,   32'h7FFFFFFF, 1'b0});
        vecs.push_back('{"zero_m",     32'h00000000,   32'h00001234,   32'h00000000, 1'b0});
        vecs.push_back('{"zero_q",     32'hDEADBEEF,   32'h00000000,   32'h00000000, 1'b0});
        vecs.push_back('{"mul_5x2",    32'd5,          32'd2,          32'h0000000A, 1'b0});

        reset        = 1'b1;
        enable       = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        #1;
        check("rst_result", 64'(result), 64'd0);
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_exception", 64'(exception), 64'd0);
        @(negedge clock);
        @(negedge clock);
        reset  = 1'b0;
        chk_en = 1;
        @(negedge clock);

        foreach (vecs[i])
            run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].e);

        // Enable held through BUSY with operands changing, then back-to-back.
        multiplicand = 32'd3;
        multiplier   = 32'd4;
        enable       = 1'b1;
        @(posedge clock);
        @(negedge clock);
        t0           = cyc;
        multiplicand = 32'd9;
        multiplier   = 32'd9;
        wait_ready("held_3x4", t0, seen);
        check("held_3x4_result", 64'(result), 64'h0000000C);
        @(negedge clock);
        t0     = cyc;
        enable = 1'b0;
        wait_ready("b2b_9x9", t0, seen);
        check("b2b_9x9_result", 64'(result), 64'h00000051);
        @(negedge clock);

        // Async reset in the middle of 5*5.
        multiplicand = 32'd5;
        multiplier   = 32'd5;
        enable       = 1'b1;
        @(posedge clock);
        @(negedge clock);
        enable = 1'b0;
        repeat (10) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("midrst_result", 64'(result), 64'd0);
        check("midrst_ready", 64'(ready), 64'd0);
        check("midrst_exception", 64'(exception), 64'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        cnt   = 0;
        for (int k = 0; k < W + 8; k++) begin
            @(negedge clock);
            if (ready) cnt++;
        end
        check("midrst_no_ready", 64'(cnt), 64'd0);

        run_op("post_3x3", 32'd3, 32'd3, 32'h00000009, 1'b0);

        repeat (3) @(negedge clock);
        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
